host_burst_feeder: RTL
======================

// Module: host_burst_feeder
// PURPOSE
// Host-side transmitter for the accelerator's con_valid/con_ready load interface.
// Fetches one burst of DATA_WIDTH words from host memory into a local buffer, then offers word 0.
// After the device's ready handshake it streams the remaining words back-to-back; the device samples each word in consecutive cycles without re-checking valid.
// A test sequencer issues one command per burst: kernel burst len 12, input burst len 4.
// PARAMETERS
// DATA_WIDTH      16  width of one streamed word
// ADDR_WIDTH      20  host memory address width (= LOG2_OF_MEM_HEIGHT)
// MAX_BURST       12  buffer depth; longest burst in words
// PORTS
// clk            in   1           clock
// arst_n_in      in   1           asynchronous reset, active low
// cmd_valid      in   1           burst command offered
// cmd_ready      out  1           high only in IDLE
// cmd_base_addr  in   ADDR_WIDTH  address of first word
// cmd_len        in   4           words in burst (0..15)
// mem_re         out  1           host memory read enable
// mem_addr       out  ADDR_WIDTH  host memory read address
// mem_rdata      in   DATA_WIDTH  read data, valid 1 cycle after mem_re
// con_valid      out  1           word 0 offered / stream word valid
// con_ready      in   1           device ready (driven by device FSM)
// con_data       out  DATA_WIDTH  streamed word
// con_data_oe    out  1           feeder drives shared data bus
// driving_cons   in   1           device owns shared bus (output phase)
// burst_done     out  1           1-cycle pulse, burst finished
// busy           out  1           state != IDLE
// proto_err      out  1           sticky: bus conflict during STREAM
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except cmd_ready=1; buffer, counters and proto_err cleared.
// - FSM IDLE -> FETCH -> OFFER -> STREAM -> IDLE.
// - IDLE: accept on cmd_valid. Effective length L = min(cmd_len, MAX_BURST).
//   - L=0: no fetch; burst_done pulses next cycle and the FSM stays in IDLE.
// - FETCH: mem_re=1 for L cycles; mem_addr = base, base+1, ... base+L-1 (ADDR_WIDTH wrap).
//   - Each mem_rdata is captured into buf[i] one cycle after its read.
//   - The FSM moves to OFFER once buf[L-1] is written. With cmd accepted in cycle T, con_valid first rises in cycle T+L+2.
// - OFFER: con_valid=1, con_data=buf[0], con_data_oe=1.
//   - If driving_cons=1: con_valid=0 and oe=0; wait with no error.
//   - Word 0 transfers in a cycle with con_valid & con_ready & !driving_cons.
//   - After the transfer: L=1 -> burst_done, IDLE; otherwise STREAM.
// - STREAM: words 1..L-1 go out on consecutive cycles, con_valid=1, con_ready ignored.
//   - After the last word: burst_done pulses in the next cycle and the FSM returns to IDLE, so cmd_ready=1 in that same cycle.
//   - If driving_cons=1 during STREAM: oe=0 for that cycle, proto_err sets (sticky until reset), word counter still advances. The word is lost and the FSM is not stalled.
// - con_data is held at the last value when not valid.
// - con_data_oe = con_valid in all states.
// - Counters: word index 4 bits, saturating at L-1, never wrapping.
// - cmd_valid outside IDLE is ignored (not queued).
// - Async reset mid-burst: immediate return to IDLE. The buffer is discarded and a partial burst is never resumed.
// TESTING
// - Kernel burst: base=0x100, L=12, mem[i]=i+1, con_ready already high.
//   -> con_valid high 12 consecutive cycles from T+14; data 1..12; burst_done at T+26.
// - Input burst: L=4, con_ready held low 5 cycles after OFFER.
//   -> con_valid=1, data=buf[0] held 5 cycles; then 4 words back-to-back; done pulse.
// - L=1 and cmd_len=0. L=1 -> one word then done. cmd_len=0 -> no mem_re, done 1 cycle after accept.
//   - cmd_len=15 -> clamped: exactly 12 reads, 12 words.
// - driving_cons=1 in OFFER for 3 cycles -> no transfer, proto_err=0.
//   - driving_cons=1 in STREAM word 2 -> oe=0 that cycle, proto_err=1 persists, burst ends on schedule.
// - arst_n_in low during FETCH cycle 3 -> busy=0, cmd_ready=1, no con_valid.
//   - A new L=4 burst afterwards streams correct fresh data.
// - Address wrap: base=2^ADDR_WIDTH-2, L=4 -> mem_addr sequence FFFFE, FFFFF, 0, 1.

Source files
------------

// File: rtl/host_burst_feeder.sv
// ============================================================================
// Module   : host_burst_feeder
// Purpose  : Fetches a burst of words from host memory into a local buffer, then
//            streams them to the device over the con_valid/con_ready interface.
// Revision : 1.0
// ============================================================================
`default_nettype none

module host_burst_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int MAX_BURST  = 12
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [3:0]            cmd_len,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  con_valid,
    input  logic                  con_ready,
    output logic [DATA_WIDTH-1:0] con_data,
    output logic                  con_data_oe,
    input  logic                  driving_cons,
    output logic                  burst_done,
    output logic                  busy,
    output logic                  proto_err
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_OFFER  = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              len_q, len_d;
    logic [3:0]              rd_cnt_q, rd_cnt_d;
    logic [3:0]              wr_cnt_q, wr_cnt_d;
    logic [3:0]              idx_q, idx_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   last_q, last_d;
    logic [DATA_WIDTH-1:0]   buf_q [MAX_BURST];
    logic                    buf_we;
    logic [3:0]              eff_len;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            idx_q     <= '0;
            rd_pend_q <= 1'b0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            last_q    <= '0;
            for (int i = 0; i < MAX_BURST; i++) buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            idx_q     <= idx_d;
            rd_pend_q <= rd_pend_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            last_q    <= last_d;
            if (buf_we) buf_q[wr_cnt_q] <= mem_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        err_d     = err_q;
        mem_re    = 1'b0;
        con_valid = 1'b0;
        buf_we    = 1'b0;
        eff_len   = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    len_d    = eff_len;
                    addr_d   = cmd_base_addr;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    idx_d    = '0;
                    if (eff_len == 4'd0) done_d  = 1'b1;
                    else                 state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rd_cnt_q < len_q) begin
                    mem_re   = 1'b1;
                    addr_d   = addr_q + 1'b1;
                    rd_cnt_d = rd_cnt_q + 4'd1;
                end
                // Read data lags its request by one cycle; leave once the last word lands.
                if (rd_pend_q) begin
                    buf_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 4'd1;
                    if (wr_cnt_q == len_q - 4'd1) state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (!driving_cons) begin
                    con_valid = 1'b1;
                    if (con_ready) begin
                        if (len_q == 4'd1) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = 4'd1;
                            state_d = S_STREAM;
                        end
                    end
                end
            end
            S_STREAM: begin
                // The device samples blindly, so a bus conflict drops the word rather than stalling.
                if (driving_cons) err_d     = 1'b1;
                else              con_valid = 1'b1;
                if (idx_q == len_q - 4'd1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rd_pend_d = mem_re;
        con_data  = con_valid ? buf_q[idx_q] : last_q;
        last_d    = con_data;
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign mem_addr    = addr_q;
    assign con_data_oe = con_valid;
    assign burst_done  = done_q;
    assign proto_err   = err_q;

endmodule

`default_nettype wire
